// File: rtl/trap_ctrl_v2_if.sv
// CSR access bus between the MEM-stage Zicsr datapath and the trap controller.
// The master issues the access; the slave returns the old CSR value combinationally.
interface trap_ctrl_v2_if #(
    parameter int XLEN = 32
);
    logic            csr_rw_in;
    logic [1:0]      csr_wsc_mode_in;
    logic            csr_w_imm_mux;
    logic [11:0]     csr_rw_addr_in;
    logic [XLEN-1:0] csr_w_data_reg;
    logic [4:0]      csr_w_data_imm;
    logic [XLEN-1:0] csr_r_data_out;

    modport master (
        output csr_rw_in,
        output csr_wsc_mode_in,
        output csr_w_imm_mux,
        output csr_rw_addr_in,
        output csr_w_data_reg,
        output csr_w_data_imm,
        input  csr_r_data_out
    );

    modport slave (
        input  csr_rw_in,
        input  csr_wsc_mode_in,
        input  csr_w_imm_mux,
        input  csr_rw_addr_in,
        input  csr_w_data_reg,
        input  csr_w_data_imm,
        output csr_r_data_out
    );
endinterface

// File: rtl/trap_ctrl_v2.sv
// Machine-mode trap controller for the MEM stage: M-mode CSR file, prioritised
// exceptions and interrupts, direct/vectored mtvec, and a one-cycle drain sequencer.
module trap_ctrl_v2 #(
    parameter int          XLEN        = 32,
    parameter int          NUM_IRQ     = 8,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    trap_ctrl_v2_if.slave      csr,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               inst_valid_in,
    input  logic [XLEN-1:0]    inst_in,
    input  logic [XLEN-1:0]    fault_addr_in,
    input  logic               illegal_inst,
    input  logic               l_access_fault,
    input  logic               s_access_fault,
    input  logic               ecall_m,
    input  logic               mret,
    input  logic [XLEN-1:0]    epc_cur,
    input  logic [XLEN-1:0]    epc_next,
    output logic [XLEN-1:0]    PC_redirect,
    output logic               redirect_mux,
    output logic               reg_FD_flush,
    output logic               reg_DE_flush,
    output logic               reg_EM_flush,
    output logic               reg_MW_flush,
    output logic               RegWrite_cancel,
    output logic               trap_busy
);
    localparam int          IRQ_LSB    = 16;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;

    typedef enum logic {IDLE, DRAIN} state_e;

    state_e             state_q, state_d;
    logic               mst_mie_q, mst_mie_d;
    logic               mst_mpie_q, mst_mpie_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic [NUM_IRQ-1:0] mip_q, mip_d;
    logic [XLEN-1:0]    mtvec_q, mtvec_d;
    logic [XLEN-1:0]    mscratch_q, mscratch_d;
    logic [XLEN-1:0]    mepc_q, mepc_d;
    logic [XLEN-1:0]    mcause_q, mcause_d;
    logic [XLEN-1:0]    mtval_q, mtval_d;

    logic               idle;
    logic [NUM_IRQ-1:0] int_pend;
    logic               exc;
    logic [XLEN-1:0]    exc_cause, exc_tval;
    logic               irq_hit;
    logic [3:0]         irq_idx;
    logic [4:0]         irq_code;
    logic               take_int, trap, do_mret;
    logic [XLEN-1:0]    rdata, src, wval;
    logic               wen, csr_we;
    logic [XLEN-1:0]    mstatus_rd, mie_full, mip_full;
    logic [XLEN-1:0]    trap_base, vec_off;

    assign idle       = (state_q == IDLE);
    assign int_pend   = mip_q & mie_q & {NUM_IRQ{mst_mie_q}};
    assign mstatus_rd = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mst_mpie_q,
                         3'b000, mst_mie_q, 3'b000};
    assign mie_full   = XLEN'(mie_q) << IRQ_LSB;
    assign mip_full   = XLEN'(mip_q) << IRQ_LSB;
    assign trap_base  = {mtvec_q[XLEN-1:2], 2'b00};
    // Interrupt k uses cause code 16+k, which is just k with bit 4 set.
    assign irq_code   = {1'b1, irq_idx};
    assign vec_off    = {{(XLEN-7){1'b0}}, irq_code, 2'b00};

    always_comb begin
        exc       = 1'b0;
        exc_cause = '0;
        exc_tval  = '0;
        if (idle && inst_valid_in) begin
            priority case (1'b1)
                illegal_inst: begin
                    exc       = 1'b1;
                    exc_cause = XLEN'(2);
                    exc_tval  = inst_in;
                end
                ecall_m: begin
                    exc       = 1'b1;
                    exc_cause = XLEN'(11);
                end
                l_access_fault: begin
                    exc       = 1'b1;
                    exc_cause = XLEN'(5);
                    exc_tval  = fault_addr_in;
                end
                s_access_fault: begin
                    exc       = 1'b1;
                    exc_cause = XLEN'(7);
                    exc_tval  = fault_addr_in;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (int_pend[k]) begin
                irq_hit = 1'b1;
                irq_idx = k[3:0];
            end
        end
    end

    assign take_int = idle && inst_valid_in && !exc && irq_hit;
    assign trap     = exc || take_int;
    assign do_mret  = idle && inst_valid_in && !trap && mret;

    always_comb begin
        rdata = '0;
        unique case (csr.csr_rw_addr_in)
            A_MSTATUS:  rdata = mstatus_rd;
            A_MIE:      rdata = mie_full;
            A_MTVEC:    rdata = mtvec_q;
            A_MSCRATCH: rdata = mscratch_q;
            A_MEPC:     rdata = mepc_q;
            A_MCAUSE:   rdata = mcause_q;
            A_MTVAL:    rdata = mtval_q;
            A_MIP:      rdata = mip_full;
            default:    rdata = '0;
        endcase
    end

    assign csr.csr_r_data_out = rdata;

    always_comb begin
        src = csr.csr_w_imm_mux ? {{(XLEN-5){1'b0}}, csr.csr_w_data_imm}
                                : csr.csr_w_data_reg;
        wval = rdata;
        wen  = 1'b0;
        unique case (csr.csr_wsc_mode_in)
            2'b01: begin
                wval = src;
                wen  = 1'b1;
            end
            2'b10: begin
                wval = rdata | src;
                wen  = |src;
            end
            2'b11: begin
                wval = rdata & ~src;
                wen  = |src;
            end
            default: ;
        endcase
    end

    assign csr_we = csr.csr_rw_in && inst_valid_in && idle && !trap && wen;

    always_comb begin
        redirect_mux    = trap || do_mret;
        reg_FD_flush    = trap || do_mret;
        reg_DE_flush    = trap || do_mret;
        reg_EM_flush    = trap || do_mret;
        reg_MW_flush    = trap;
        RegWrite_cancel = trap;
        trap_busy       = (state_q == DRAIN);
        PC_redirect     = '0;
        if (trap) begin
            PC_redirect = trap_base;
            if (take_int && mtvec_q[1:0] == 2'b01)
                PC_redirect = trap_base + vec_off;
        end else if (do_mret) begin
            PC_redirect = mepc_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mip_d      = irq_in;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        unique case (state_q)
            IDLE:    if (trap || do_mret) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (csr_we) begin
            unique case (csr.csr_rw_addr_in)
                A_MSTATUS: begin
                    mst_mie_d  = wval[3];
                    mst_mpie_d = wval[7];
                end
                A_MIE:      mie_d      = wval[IRQ_LSB +: NUM_IRQ];
                A_MTVEC:    mtvec_d    = wval;
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_d   = wval;
                A_MTVAL:    mtval_d    = wval;
                default: ;
            endcase
        end

        // mret owns MIE/MPIE even if the same instruction also wrote mstatus.
        if (trap) begin
            mepc_d     = take_int ? {epc_next[XLEN-1:2], 2'b00}
                                  : {epc_cur[XLEN-1:2], 2'b00};
            mcause_d   = take_int ? {1'b1, {(XLEN-6){1'b0}}, irq_code}
                                  : exc_cause;
            mtval_d    = take_int ? '0 : exc_tval;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (do_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            state_q    <= state_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mip_q      <= mip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end
endmodule

// File: tb/tb_trap_ctrl_v2.sv
// Bench for trap_ctrl_v2: CSR-map model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_trap_ctrl_v2;
    localparam int          N       = 8;
    localparam logic [31:0] MTV_RST = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [N-1:0] irq_in;
    logic        inst_valid_in;
    logic [31:0] inst_in, fault_addr_in, epc_cur, epc_next;
    logic        illegal_inst, l_access_fault, s_access_fault, ecall_m, mret;
    logic [31:0] PC_redirect;
    logic        redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush;
    logic        reg_MW_flush, RegWrite_cancel, trap_busy;

    trap_ctrl_v2_if #(.XLEN(32)) bus ();

    trap_ctrl_v2 #(.XLEN(32), .NUM_IRQ(N), .MTVEC_RESET(MTV_RST)) dut (
        .clk             (clk),
        .rst             (rst),
        .csr             (bus),
        .irq_in          (irq_in),
        .inst_valid_in   (inst_valid_in),
        .inst_in         (inst_in),
        .fault_addr_in   (fault_addr_in),
        .illegal_inst    (illegal_inst),
        .l_access_fault  (l_access_fault),
        .s_access_fault  (s_access_fault),
        .ecall_m         (ecall_m),
        .mret            (mret),
        .epc_cur         (epc_cur),
        .epc_next        (epc_next),
        .PC_redirect     (PC_redirect),
        .redirect_mux    (redirect_mux),
        .reg_FD_flush    (reg_FD_flush),
        .reg_DE_flush    (reg_DE_flush),
        .reg_EM_flush    (reg_EM_flush),
        .reg_MW_flush    (reg_MW_flush),
        .RegWrite_cancel (RegWrite_cancel),
        .trap_busy       (trap_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] flags();
        return {redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush,
                reg_MW_flush, RegWrite_cancel, trap_busy};
    endfunction

    // Model: the CSR file as an address-keyed map plus a drain countdown.
    logic [31:0] mc  [logic [11:0]];
    logic [31:0] nmc [logic [11:0]];
    int drain, ndrain;

    task automatic m_reset();
        mc.delete();
        mc[12'h300] = 0; mc[12'h304] = 0; mc[12'h305] = MTV_RST;
        mc[12'h340] = 0; mc[12'h341] = 0; mc[12'h342] = 0;
        mc[12'h343] = 0; mc[12'h344] = 0;
        drain = 0;
    endtask

    function automatic logic [31:0] mread(input logic [11:0] a);
        if (!mc.exists(a)) return 32'h0;
        if (a == 12'h300) return mc[a] | 32'h0000_1800;
        return mc[a];
    endfunction

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h00FF_0000;
            12'h305, 12'h340, 12'h342, 12'h343: return 32'hFFFF_FFFF;
            12'h341: return 32'hFFFF_FFFC;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_eval();
        logic [31:0] rd, pc, cause, tval, epc, st, pend, src, nv, wm;
        logic [11:0] a;
        bit trap, isint, mr, busy, doit;
        int bitn;
        if (rst) m_reset();
        busy = (drain != 0);
        a = bus.csr_rw_addr_in;
        rd = mread(a);
        trap = 0; isint = 0; mr = 0; bitn = 0;
        cause = 0; tval = 0; epc = 0;
        st = mc[12'h300];
        if (!rst && !busy && inst_valid_in) begin
            if (illegal_inst) begin trap = 1; cause = 2; tval = inst_in; end
            else if (ecall_m) begin trap = 1; cause = 11; end
            else if (l_access_fault) begin trap = 1; cause = 5; tval = fault_addr_in; end
            else if (s_access_fault) begin trap = 1; cause = 7; tval = fault_addr_in; end
            if (trap) epc = epc_cur;
            else begin
                pend = mc[12'h344] & mc[12'h304] & (st[3] ? 32'hFFFF_FFFF : 32'h0);
                for (int b = 16; b < 32; b++)
                    if (pend[b] && !isint) begin isint = 1; bitn = b; end
                if (isint) begin
                    trap = 1; cause = 32'h8000_0000 | 32'(bitn);
                    epc = epc_next; tval = 0;
                end else if (mret) mr = 1;
            end
        end
        pc = 0;
        if (trap) begin
            pc = mc[12'h305] & 32'hFFFF_FFFC;
            if (isint && mc[12'h305][1:0] == 2'b01) pc = pc + 32'(4 * bitn);
        end else if (mr) pc = mc[12'h341];
        chk("mon_pc", PC_redirect, pc);
        chk("mon_flags", {25'b0, flags()},
            {25'b0, trap | mr, trap | mr, trap | mr, trap | mr, trap, trap, busy});
        chk("mon_rdata", bus.csr_r_data_out, rd);

        nmc = mc;
        ndrain = 0;
        if (!rst && !busy && inst_valid_in && bus.csr_rw_in && !trap) begin
            src = bus.csr_w_imm_mux ? {27'b0, bus.csr_w_data_imm} : bus.csr_w_data_reg;
            doit = 0; nv = rd;
            case (bus.csr_wsc_mode_in)
                2'b01: begin nv = src; doit = 1; end
                2'b10: begin nv = rd | src; doit = (src != 0); end
                2'b11: begin nv = rd & ~src; doit = (src != 0); end
                default: ;
            endcase
            wm = wmask(a);
            if (doit && wm != 0) nmc[a] = (mc[a] & ~wm) | (nv & wm);
        end
        if (trap) begin
            nmc[12'h341] = epc & 32'hFFFF_FFFC;
            nmc[12'h342] = cause;
            nmc[12'h343] = tval;
            nmc[12'h300] = st[3] ? 32'h80 : 32'h0;
            ndrain = 1;
        end else if (mr) begin
            nmc[12'h300] = 32'h80 | (st[7] ? 32'h8 : 32'h0);
            ndrain = 1;
        end
        nmc[12'h344] = 32'(irq_in) << 16;
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            model_eval();
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else begin
                mc = nmc;
                drain = ndrain;
            end
        end
    end

    task automatic idle_in();
        bus.csr_rw_in = 0; bus.csr_wsc_mode_in = 0; bus.csr_w_imm_mux = 0;
        bus.csr_rw_addr_in = 0; bus.csr_w_data_reg = 0; bus.csr_w_data_imm = 0;
        irq_in = 0; inst_valid_in = 0; inst_in = 0; fault_addr_in = 0;
        illegal_inst = 0; l_access_fault = 0; s_access_fault = 0;
        ecall_m = 0; mret = 0; epc_cur = 0; epc_next = 0;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] md,
                      input logic im, input logic [31:0] v);
        go();
        inst_valid_in = 1; bus.csr_rw_in = 1; bus.csr_rw_addr_in = a;
        bus.csr_wsc_mode_in = md; bus.csr_w_imm_mux = im;
        bus.csr_w_data_reg = v; bus.csr_w_data_imm = v[4:0];
        settle();
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        go();
        bus.csr_rw_addr_in = a;
        settle();
        chk(nm, bus.csr_r_data_out, exp);
    endtask

    initial begin
        idle_in();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        wr(12'h305, 2'b10, 0, 32'h0);
        chk("rst_mtvec", bus.csr_r_data_out, MTV_RST);
        chk("rst_outs", {25'b0, flags()}, 32'h0);
        chk("rst_pc", PC_redirect, 32'h0);
        rd_chk("mtvec_nowrite", 12'h305, MTV_RST);

        go();
        inst_valid_in = 1; illegal_inst = 1;
        epc_cur = 32'h100; inst_in = 32'hFFFF_FFFF;
        settle();
        chk("ill_pc", PC_redirect, 32'h80);
        chk("ill_flags", {25'b0, flags()}, 32'b1111110);
        rd_chk("ill_mepc", 12'h341, 32'h100);
        chk("ill_busy", {31'b0, trap_busy}, 32'h1);
        rd_chk("ill_mcause", 12'h342, 32'h2);
        rd_chk("ill_mtval", 12'h343, 32'hFFFF_FFFF);

        wr(12'h305, 2'b01, 0, 32'h1001);
        wr(12'h304, 2'b01, 0, 32'h0014_0000);
        wr(12'h300, 2'b01, 0, 32'h8);
        rd_chk("mie_rd", 12'h304, 32'h0014_0000);
        go(); irq_in = 8'b0001_0100; settle();
        go();
        irq_in = 8'b0001_0100; inst_valid_in = 1;
        epc_cur = 32'h200; epc_next = 32'h204;
        settle();
        chk("irq_pc", PC_redirect, 32'h1048);
        rd_chk("irq_mcause", 12'h342, 32'h8000_0012);
        rd_chk("irq_mepc", 12'h341, 32'h204);
        rd_chk("irq_mstatus", 12'h300, 32'h1880);

        go(); inst_valid_in = 1; mret = 1; settle();
        chk("mret_pc", PC_redirect, 32'h204);
        chk("mret_flags", {25'b0, flags()}, 32'b1111000);
        go(); inst_valid_in = 1; illegal_inst = 1; epc_cur = 32'h208; settle();
        chk("drain_ignore", {25'b0, flags()}, 32'b0000001);
        rd_chk("mret_mstatus", 12'h300, 32'h1888);
        rd_chk("drain_mcause", 12'h342, 32'h8000_0012);

        go();
        inst_valid_in = 1; ecall_m = 1; mret = 1; epc_cur = 32'h300;
        bus.csr_rw_in = 1; bus.csr_wsc_mode_in = 2'b01;
        bus.csr_rw_addr_in = 12'h340; bus.csr_w_data_reg = 32'h55;
        settle();
        chk("ecall_pc", PC_redirect, 32'h1000);
        rd_chk("ecall_mscratch", 12'h340, 32'h0);
        rd_chk("ecall_mcause", 12'h342, 32'd11);
        rd_chk("ecall_mtval", 12'h343, 32'h0);

        wr(12'h340, 2'b01, 0, 32'h55);
        wr(12'h340, 2'b11, 1, 32'h0);
        rd_chk("clr_zero", 12'h340, 32'h55);
        wr(12'h340, 2'b10, 1, 32'h3);
        rd_chk("set_imm", 12'h340, 32'h57);

        go();
        inst_valid_in = 1; l_access_fault = 1; s_access_fault = 1;
        fault_addr_in = 32'hDEAD_BEE0; epc_cur = 32'h400;
        settle();
        chk("lacc_pc", PC_redirect, 32'h1000);
        rd_chk("lacc_mcause", 12'h342, 32'd5);
        rd_chk("lacc_mtval", 12'h343, 32'hDEAD_BEE0);
        go(); inst_valid_in = 1; s_access_fault = 1; fault_addr_in = 32'h44; settle();
        rd_chk("sacc_mcause", 12'h342, 32'd7);

        wr(12'h300, 2'b10, 1, 32'h8);
        go(); irq_in = 8'h10; settle();
        go();
        irq_in = 8'h10; inst_valid_in = 1; epc_next = 32'h504;
        bus.csr_rw_in = 1; bus.csr_wsc_mode_in = 2'b11; bus.csr_w_imm_mux = 1;
        bus.csr_rw_addr_in = 12'h300; bus.csr_w_data_imm = 5'd8;
        settle();
        chk("prewrite_pc", PC_redirect, 32'h1050);
        rd_chk("prewrite_mstatus", 12'h300, 32'h1880);
        rd_chk("prewrite_mepc", 12'h341, 32'h504);

        go(); inst_valid_in = 1; mret = 1; settle();
        go(); settle();
        go(); inst_valid_in = 1; illegal_inst = 1; epc_cur = 32'h600; settle();
        go(); rst = 1; bus.csr_rw_addr_in = 12'h342; settle();
        chk("rst_drain_busy", {31'b0, trap_busy}, 32'h0);
        chk("rst_drain_mcause", bus.csr_r_data_out, 32'h0);
        go(); rst = 0; settle();
        rd_chk("post_rst_mtvec", 12'h305, MTV_RST);
        go(); settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
